// File: rtl/sparc_id_pkg.sv
// Shared encodings and the ID-stage control bundle for the SPARC-subset front end.
package sparc_id_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    OP_FMT2  = 2'b00,
    OP_CALL  = 2'b01,
    OP_ARITH = 2'b10,
    OP_MEM   = 2'b11
  } op_e;

  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  localparam logic [5:0] OP3_JMPL     = 6'b111000;
  localparam logic [5:0] OP3_ALU_MAX  = 6'h1F;
  localparam logic [5:0] OP3_SHIFT_LO = 6'h25;
  localparam logic [5:0] OP3_SHIFT_HI = 6'h27;
  localparam logic [5:0] OP3_MEM_MAX  = 6'h07;
  localparam logic [5:0] OP3_LDSB     = 6'h09;
  localparam logic [5:0] OP3_LDSH     = 6'h0A;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_PASSB = 6'b001110;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_DOUBLE = 2'b11
  } size_e;

  typedef struct packed {
    logic       jmpl_instr;
    logic       read_write;
    logic       se_dm;
    logic       load_instr;
    logic       rf_enable;
    logic [1:0] size_dm;
    logic       modify_cc;
    logic       call_instr;
    logic [5:0] alu_op3;
  } ctrl_t;

  // The low two op3 bits of a load/store name the access width in SPARC's own order.
  function automatic logic [1:0] size_from_op3(input logic [1:0] low);
    logic [1:0] sz;
    case (low)
      2'b01:   sz = SIZE_BYTE;
      2'b10:   sz = SIZE_HALF;
      2'b00:   sz = SIZE_WORD;
      default: sz = SIZE_DOUBLE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/sparc_id_decoder.sv
// Combinational ID-stage decoder: instruction word in, unmuxed control bundle out.
// ILLEGAL_FLAG_EN adds an illegal_instr output for nonzero unrecognised words.
module sparc_id_decoder
  import sparc_id_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        b_instr,
  output logic        a_bit
`ifdef ILLEGAL_FLAG_EN
  ,
  output logic        illegal_instr
`endif
);

  logic [2:0] op2;
  logic [5:0] op3;
  logic       legal;
  logic       unused_bits;

  assign op2 = instr[24:22];
  assign op3 = instr[24:19];
  assign unused_bits = ^{instr[28:25], instr[18:0]};

  // Anything not matched below leaves the whole bundle at zero.
  always_comb begin
    ctrl    = '0;
    b_instr = 1'b0;
    a_bit   = 1'b0;
    legal   = 1'b0;
    case (instr[31:30])
      OP_CALL: begin
        legal           = 1'b1;
        ctrl.call_instr = 1'b1;
        ctrl.rf_enable  = 1'b1;
        ctrl.alu_op3    = ALU_ADD;
      end
      OP_FMT2: begin
        if (op2 == OP2_BICC) begin
          legal   = 1'b1;
          b_instr = 1'b1;
          a_bit   = instr[29];
        end else if (op2 == OP2_SETHI) begin
          legal          = 1'b1;
          ctrl.rf_enable = 1'b1;
          ctrl.alu_op3   = ALU_PASSB;
        end
      end
      OP_ARITH: begin
        if (op3 <= OP3_ALU_MAX || (op3 >= OP3_SHIFT_LO && op3 <= OP3_SHIFT_HI)) begin
          legal          = 1'b1;
          ctrl.rf_enable = 1'b1;
          ctrl.alu_op3   = op3;
          ctrl.modify_cc = op3[4];
        end else if (op3 == OP3_JMPL) begin
          legal           = 1'b1;
          ctrl.jmpl_instr = 1'b1;
          ctrl.rf_enable  = 1'b1;
          ctrl.alu_op3    = ALU_ADD;
        end
      end
      default: begin
        // op3[2] separates stores from loads; op3[3] marks the signed loads.
        if (op3 <= OP3_MEM_MAX || op3 == OP3_LDSB || op3 == OP3_LDSH) begin
          legal           = 1'b1;
          ctrl.alu_op3    = ALU_ADD;
          ctrl.load_instr = ~op3[2];
          ctrl.read_write = op3[2];
          ctrl.rf_enable  = ~op3[2];
          ctrl.se_dm      = op3[3];
          ctrl.size_dm    = size_from_op3(op3[1:0]);
        end
      end
    endcase
  end

`ifdef ILLEGAL_FLAG_EN
  assign illegal_instr = ~legal && (instr != 32'h0);
`else
  logic unused_legal;
  assign unused_legal = legal;
`endif

endmodule

// File: rtl/sparc_id_control.sv
// Fetch-to-decode front end: byte memory, IF/ID register, decoder and NOP-insertion mux.
// ILLEGAL_FLAG_EN adds the illegal_instr output (not masked by S).
module sparc_id_control
  import sparc_id_pkg::*;
#(
  parameter int MEM_DEPTH = 256
)
(
  input  logic        Clk,
  input  logic        R,
  input  logic        mem_we,
  input  logic [7:0]  mem_waddr,
  input  logic [7:0]  mem_wdata,
  input  logic [7:0]  pc,
  input  logic        LE,
  input  logic        S,
  output logic [31:0] instr,
  output logic        jmpl_instr,
  output logic        read_write,
  output logic        se_dm,
  output logic        load_instr,
  output logic        rf_enable,
  output logic [1:0]  size_dm,
  output logic        modify_cc,
  output logic        call_instr,
  output logic [5:0]  alu_op3,
  output logic        b_instr,
  output logic        a_bit
`ifdef ILLEGAL_FLAG_EN
  ,
  output logic        illegal_instr
`endif
);

  logic [7:0]        mem [MEM_DEPTH];
  logic [ADDR_W-1:0] pc1, pc2, pc3;
  logic [31:0]       fetch_word;
  ctrl_t             ctrl_dec, ctrl_out;

  // Preload memory is never reset; its contents survive R.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // 8-bit address arithmetic gives the modulo-256 wrap for free.
  assign pc1 = pc + 8'd1;
  assign pc2 = pc + 8'd2;
  assign pc3 = pc + 8'd3;
  assign fetch_word = {mem[pc], mem[pc1], mem[pc2], mem[pc3]};

  always_ff @(posedge Clk) begin
    if (R)       instr <= 32'h0;
    else if (LE) instr <= fetch_word;
  end

  sparc_id_decoder u_decoder (
    .instr        (instr),
    .ctrl         (ctrl_dec),
    .b_instr      (b_instr),
    .a_bit        (a_bit)
`ifdef ILLEGAL_FLAG_EN
    ,
    .illegal_instr(illegal_instr)
`endif
  );

  // Bubble insertion only kills the pipeline-bound bundle; branch info still reaches fetch.
  assign ctrl_out = S ? '0 : ctrl_dec;

  assign jmpl_instr = ctrl_out.jmpl_instr;
  assign read_write = ctrl_out.read_write;
  assign se_dm      = ctrl_out.se_dm;
  assign load_instr = ctrl_out.load_instr;
  assign rf_enable  = ctrl_out.rf_enable;
  assign size_dm    = ctrl_out.size_dm;
  assign modify_cc  = ctrl_out.modify_cc;
  assign call_instr = ctrl_out.call_instr;
  assign alu_op3    = ctrl_out.alu_op3;

endmodule

// File: tb/tb_sparc_id_control.sv
// Self-checking bench for sparc_id_control: directed literal checks plus randomized traffic
// against a behavioural model; checks illegal_instr when ILLEGAL_FLAG_EN is defined.
module tb_sparc_id_control;

  logic        Clk = 1'b0;
  logic        R, mem_we, LE, S;
  logic [7:0]  mem_waddr, mem_wdata, pc;
  logic [31:0] instr;
  logic        jmpl_instr, read_write, se_dm, load_instr, rf_enable;
  logic [1:0]  size_dm;
  logic        modify_cc, call_instr, b_instr, a_bit;
  logic [5:0]  alu_op3;
`ifdef ILLEGAL_FLAG_EN
  logic        illegal_instr;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  logic [7:0]  model_mem [256];
  logic [31:0] model_instr = 32'h0;

  always #5 Clk = ~Clk;

  sparc_id_control dut (
    .Clk(Clk), .R(R), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .pc(pc), .LE(LE), .S(S), .instr(instr), .jmpl_instr(jmpl_instr),
    .read_write(read_write), .se_dm(se_dm), .load_instr(load_instr),
    .rf_enable(rf_enable), .size_dm(size_dm), .modify_cc(modify_cc),
    .call_instr(call_instr), .alu_op3(alu_op3), .b_instr(b_instr), .a_bit(a_bit)
`ifdef ILLEGAL_FLAG_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  function automatic logic [16:0] pack(input bit jm, rw, se, ld, rf, input logic [1:0] sz,
                                       input bit mcc, cl, input logic [5:0] alu, input bit b, a);
    return {jm, rw, se, ld, rf, sz, mcc, cl, alu, b, a};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {jmpl_instr, read_write, se_dm, load_instr, rf_enable, size_dm,
            modify_cc, call_instr, alu_op3, b_instr, a_bit};
  endfunction

  function automatic bit model_legal(input logic [31:0] w);
    int op  = int'(w[31:30]);
    int op2 = int'(w[24:22]);
    int o3  = int'(w[24:19]);
    return (op == 1) || (op == 0 && (op2 == 2 || op2 == 4)) ||
           (op == 2 && (o3 <= 31 || (o3 >= 37 && o3 <= 39) || o3 == 56)) ||
           (op == 3 && (o3 <= 7 || o3 == 9 || o3 == 10));
  endfunction

  function automatic logic [16:0] model_ctrl(input logic [31:0] w, input logic s);
    logic [1:0] size_tab [4];
    int op  = int'(w[31:30]);
    int op2 = int'(w[24:22]);
    int o3  = int'(w[24:19]);
    bit jm = 0, rw = 0, se = 0, ld = 0, rf = 0, mcc = 0, cl = 0, b = 0, a = 0;
    logic [1:0] sz = 2'b00;
    logic [5:0] alu = 6'd0;
    size_tab[0] = 2'b10; size_tab[1] = 2'b00; size_tab[2] = 2'b01; size_tab[3] = 2'b11;
    if (op == 1) begin
      cl = 1; rf = 1;
    end else if (op == 0 && op2 == 2) begin
      b = 1; a = w[29];
    end else if (op == 0 && op2 == 4) begin
      rf = 1; alu = 6'd14;
    end else if (op == 2 && (o3 <= 31 || (o3 >= 37 && o3 <= 39))) begin
      rf = 1; alu = 6'(o3); mcc = (o3 >= 16 && o3 <= 31);
    end else if (op == 2 && o3 == 56) begin
      jm = 1; rf = 1;
    end else if (op == 3 && (o3 <= 7 || o3 == 9 || o3 == 10)) begin
      rw = (o3 >= 4 && o3 <= 7);
      ld = !rw; rf = !rw;
      se = (o3 >= 8);
      sz = size_tab[o3 % 4];
    end
    if (s) begin
      jm = 0; rw = 0; se = 0; ld = 0; rf = 0; sz = 2'b00; mcc = 0; cl = 0; alu = 6'd0;
    end
    return pack(jm, rw, se, ld, rf, sz, mcc, cl, alu, b, a);
  endfunction

  // Reference register/memory update: the fetch sees memory from before this edge's write.
  always @(posedge Clk) begin
    logic [31:0] w;
    w = {model_mem[pc], model_mem[(int'(pc) + 1) % 256],
         model_mem[(int'(pc) + 2) % 256], model_mem[(int'(pc) + 3) % 256]};
    if (R)       model_instr = 32'h0;
    else if (LE) model_instr = w;
    if (mem_we)  model_mem[mem_waddr] = mem_wdata;
  end

  always @(negedge Clk) begin
    if (check_en) begin
      n_cmp++;
      if (instr !== model_instr) begin
        n_bad++;
        $display("[TB] FAIL model_instr t=%0t dut=%h exp=%h", $time, instr, model_instr);
      end
      n_cmp++;
      if (dut_vec() !== model_ctrl(model_instr, S)) begin
        n_bad++;
        $display("[TB] FAIL model_ctrl t=%0t instr=%h S=%b dut=%h exp=%h", $time, instr, S,
                 dut_vec(), model_ctrl(model_instr, S));
      end
`ifdef ILLEGAL_FLAG_EN
      n_cmp++;
      if (illegal_instr !== (!model_legal(model_instr) && model_instr != 32'h0)) begin
        n_bad++;
        $display("[TB] FAIL model_illegal t=%0t instr=%h dut=%b", $time, instr, illegal_instr);
      end
`endif
    end
  end

  task automatic applyStimulus(input logic r, le, s, input logic [7:0] p,
                               input logic we, input logic [7:0] wa, wd);
    R = r; LE = le; S = s; pc = p; mem_we = we; mem_waddr = wa; mem_wdata = wd;
    @(posedge Clk);
    #2;
  endtask

  task automatic writeWord(input logic [7:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'(a + 8'(k)), w[31 - 8*k -: 8]);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] ei, input logic [16:0] ec);
    n_cmp++;
    if (instr !== ei) begin
      n_bad++;
      $display("[TB] FAIL %s instr dut=%h exp=%h", name, instr, ei);
    end
    n_cmp++;
    if (dut_vec() !== ec) begin
      n_bad++;
      $display("[TB] FAIL %s ctrl dut=%h exp=%h", name, dut_vec(), ec);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'(i), 8'($urandom));
      check_en = 1'b1;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    checkOutput("reset_state", 32'h0, 17'h0);

    writeWord(8'd0,  32'h86804002);
    writeWord(8'd4,  32'hC8084002);
    writeWord(8'd8,  32'hC8504002);
    writeWord(8'd12, 32'hC8284002);
    writeWord(8'd16, 32'h30800002);
    writeWord(8'd20, 32'h40000004);
    writeWord(8'd24, 32'h01000000);
    writeWord(8'd28, 32'h81C3E008);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00);
    checkOutput("addcc", 32'h86804002, pack(0,0,0,0,1,2'b00,1,0,6'b010000,0,0));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 8'h00, 8'h00);
    checkOutput("ldub", 32'hC8084002, pack(0,0,0,1,1,2'b00,0,0,6'd0,0,0));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd8, 1'b0, 8'h00, 8'h00);
    checkOutput("ldsh", 32'hC8504002, pack(0,0,1,1,1,2'b01,0,0,6'd0,0,0));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd12, 1'b0, 8'h00, 8'h00);
    checkOutput("stb", 32'hC8284002, pack(0,1,0,0,0,2'b00,0,0,6'd0,0,0));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd16, 1'b0, 8'h00, 8'h00);
    checkOutput("ba_a", 32'h30800002, pack(0,0,0,0,0,2'b00,0,0,6'd0,1,1));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd20, 1'b0, 8'h00, 8'h00);
    checkOutput("call", 32'h40000004, pack(0,0,0,0,1,2'b00,0,1,6'd0,0,0));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd24, 1'b0, 8'h00, 8'h00);
    checkOutput("sethi_nop", 32'h01000000, pack(0,0,0,0,1,2'b00,0,0,6'b001110,0,0));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd28, 1'b0, 8'h00, 8'h00);
    checkOutput("jmpl", 32'h81C3E008, pack(1,0,0,0,1,2'b00,0,0,6'd0,0,0));

    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 8'h00);
    checkOutput("nop_mux", 32'h86804002, 17'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd16, 1'b0, 8'h00, 8'h00);
    checkOutput("nop_mux_branch", 32'h30800002, pack(0,0,0,0,0,2'b00,0,0,6'd0,1,1));

    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00);
    checkOutput("reset_over_le", 32'h0, 17'h0);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00, 8'h00);
    checkOutput("hold", 32'hC8084002, pack(0,0,0,1,1,2'b00,0,0,6'd0,0,0));

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 8'hFE);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 8'h00, 8'h00);
    checkOutput("pc_wrap", 32'hFEFF0001, 17'h0);

    for (int i = 0; i < 2000; i++)
      applyStimulus($urandom_range(0, 31) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
                    8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));

    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
